muldiv_unit: RTL

Iterative multiply/divide unit for the 3-stage MIPS pipeline, sitting beside the ALU in the execute stage. It provides MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers. It computes at one bit per cycle, with a busy/done handshake so the hazard control can stall MFHI/MFLO until the result exists. It is generalised in operand width and supports pipeline stall and flush.

---
 rtl/muldiv_unit_pkg.sv | 8 +
 rtl/muldiv_unit_if.sv | 20 ++
 rtl/muldiv_step.sv | 21 ++
 rtl/muldiv_unit.sv | 83 ++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op and state encodings shared by the multiply/divide unit and the hazard logic
package muldiv_unit_pkg;
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, MTHI/MTLO and result signals between execute stage and muldiv_unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output stall, flush, start, op, src_a, src_b, hi_we, lo_we, wdata,
                  input busy, done, hi, lo);
  modport slave  (input stall, flush, start, op, src_a, src_b, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring shift-subtract divide iteration
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic             i_div,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_qbit
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  assign w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
  assign w_sh   = {i_hi, i_lo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, i_opnd};
  assign o_qbit = i_div & ~w_diff[WIDTH];
  assign o_hi   = i_div ? (o_qbit ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
  // quotient bit is OR-ed in by the caller, so the divide path leaves bit 0 clear
  assign o_lo   = i_div ? {i_lo[WIDTH-2:0], 1'b0} : {w_sum[0], i_lo[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle
module muldiv_unit
  import muldiv_unit_pkg::*;
#(parameter int WIDTH = 32) (
  input logic         clk,
  input logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH+1);
  md_state_e          r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_p_hi, r_p_lo, r_opnd, r_hi, r_lo;
  logic               r_div, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   w_step_hi, w_step_lo, w_abs_a, w_abs_b;
  logic               w_step_q, w_signed, w_sa, w_sb, w_go, w_adv;
  logic [2*WIDTH-1:0] w_prod;
  assign w_signed = bus.op == MD_MULT || bus.op == MD_DIV;
  assign w_sa     = w_signed & bus.src_a[WIDTH-1];
  assign w_sb     = w_signed & bus.src_b[WIDTH-1];
  assign w_abs_a  = w_sa ? -bus.src_a : bus.src_a;
  assign w_abs_b  = w_sb ? -bus.src_b : bus.src_b;
  assign w_go     = r_state == IDLE && bus.start && !bus.stall && !bus.flush;
  assign w_adv    = !bus.stall && !bus.flush;
  assign w_prod   = r_neg_q ? -{r_p_hi, r_p_lo} : {r_p_hi, r_p_lo};
  assign bus.busy = r_state == RUN || r_state == FIX;
  assign bus.done = r_state == DONE;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_hi   (r_p_hi),
    .i_lo   (r_p_lo),
    .i_opnd (r_opnd),
    .i_div  (r_div),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo),
    .o_qbit (w_step_q)
  );
  always_comb begin
    w_next = r_state;
    if (bus.flush) w_next = IDLE;
    else if (!bus.stall)
      w_next = r_state == IDLE ? (bus.start ? RUN : IDLE) :
               r_state == RUN  ? (r_cnt == CNT_W'(1) ? FIX : RUN) :
               r_state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_cnt   <= CNT_W'(WIDTH);
        r_div   <= bus.op[1];
        // a zero divisor keeps the all-ones quotient unsigned-looking for DIV too
        r_neg_q <= (w_sa ^ w_sb) & (!bus.op[1] || |bus.src_b);
        r_neg_r <= bus.op[1] & w_sa;
        r_p_hi  <= '0;
        r_p_lo  <= bus.op[1] ? w_abs_a : w_abs_b;
        r_opnd  <= bus.op[1] ? w_abs_b : w_abs_a;
      end else if (r_state == RUN && w_adv) begin
        r_cnt  <= r_cnt - 1'b1;
        r_p_hi <= w_step_hi;
        r_p_lo <= w_step_lo | {{(WIDTH-1){1'b0}}, w_step_q};
      end
      if (r_state == FIX && w_adv) begin
        r_hi <= r_div ? (r_neg_r ? -r_p_hi : r_p_hi) : w_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_div ? (r_neg_q ? -r_p_lo : r_p_lo) : w_prod[WIDTH-1:0];
      end else if (((r_state == IDLE && !bus.start) || r_state == DONE) && !bus.stall) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end
    end
  end
endmodule
